// File: rtl/waveform_config_scheduler.sv
// waveform_config_scheduler
// Holds an incoming waveform configuration in shadow registers. Signal number
// and phase increment are committed to the generator only on an accumulator
// wrap, or on a timeout, or at once when the generator is stopped. After the
// commit, a changed amplitude is handed to the amplitude transmitter over a
// 4-phase req/ack handshake.
// Optional macro AWG_MUTE_EN: adds a MUTE_CYCLES-long mute pulse after each
// commit, and holds busy/cfg_ready until that pulse has finished.
module waveform_config_scheduler #(
  parameter int unsigned WRAP_TIMEOUT = 1048576,
  parameter int unsigned TMO_W        = 21
`ifdef AWG_MUTE_EN
  ,
  parameter int unsigned MUTE_CYCLES  = 64
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_signal_number,
  input  logic [31:0] cfg_adder,
  input  logic [31:0] cfg_amplitude,
  input  logic        phase_wrap,
  output logic [7:0]  signal_number,
  output logic [31:0] adder,
  output logic [31:0] amp_value,
  output logic        amp_req,
  input  logic        amp_ack,
  output logic        busy,
  output logic        wrap_timeout,
  output logic        mute
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WRAP,
    S_APPLY,
    S_AMP_REQ,
    S_AMP_WAIT
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WRAP_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_sh_signal_number;
  logic [31:0] r_sh_adder;
  logic [31:0] r_sh_amplitude;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic        r_cfg_ready;
  logic        r_busy;
  logic        r_wrap_timeout;
  logic        r_amp_req;
  logic [7:0]  r_signal_number;
  logic [31:0] r_adder;
  logic [31:0] r_amp_value;

  // A real wrap (or a stopped generator, which never wraps) takes priority
  // over the timeout so that a coincident timeout is not reported.
  logic w_wrap_exit;
  logic w_tmo_hit;
  logic w_wait_exit;
  // High when the mute counter will be idle after the coming edge.
  logic w_mute_clear_next;

  assign w_wrap_exit = phase_wrap || (r_adder == '0);
  assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
  assign w_wait_exit = (r_state == S_WAIT_WRAP) && (w_wrap_exit || w_tmo_hit);

  // Main sequencer: accept, wait for wrap, commit, then amplitude handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= S_IDLE;
      r_sh_signal_number <= '0;
      r_sh_adder         <= '0;
      r_sh_amplitude     <= '0;
      r_tmo_cnt          <= '0;
      r_cfg_ready        <= 1'b0;
      r_busy             <= 1'b0;
      r_wrap_timeout     <= 1'b0;
      r_amp_req          <= 1'b0;
      r_signal_number    <= '0;
      r_adder            <= '0;
      r_amp_value        <= '0;
    end else begin
      r_wrap_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_valid && r_cfg_ready) begin
            r_sh_signal_number <= cfg_signal_number;
            r_sh_adder         <= cfg_adder;
            r_sh_amplitude     <= cfg_amplitude;
            r_tmo_cnt          <= '0;
            r_cfg_ready        <= 1'b0;
            r_busy             <= 1'b1;
            r_state            <= S_WAIT_WRAP;
          end else begin
            r_cfg_ready <= w_mute_clear_next;
            r_busy      <= !w_mute_clear_next;
          end
        end
        S_WAIT_WRAP: begin
          if (w_wait_exit) begin
            r_wrap_timeout <= !w_wrap_exit;
            r_state        <= S_APPLY;
          end else if (r_tmo_cnt != '1) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          r_signal_number <= r_sh_signal_number;
          r_adder         <= r_sh_adder;
          if (r_sh_amplitude != r_amp_value) begin
            r_amp_value <= r_sh_amplitude;
            r_amp_req   <= 1'b1;
            r_state     <= S_AMP_REQ;
          end else begin
            r_cfg_ready <= w_mute_clear_next;
            r_busy      <= !w_mute_clear_next;
            r_state     <= S_IDLE;
          end
        end
        S_AMP_REQ: begin
          if (amp_ack) begin
            r_amp_req <= 1'b0;
            r_state   <= S_AMP_WAIT;
          end
        end
        S_AMP_WAIT: begin
          if (!amp_ack) begin
            r_cfg_ready <= w_mute_clear_next;
            r_busy      <= !w_mute_clear_next;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AWG_MUTE_EN
  localparam int unsigned MUTE_W = $clog2(MUTE_CYCLES + 1);

  logic [MUTE_W-1:0] r_mute_cnt;
  logic              r_mute;

  // The counter is reloaded on the commit edge, so it is never idle after APPLY.
  assign w_mute_clear_next = (r_state != S_APPLY) && (r_mute_cnt <= MUTE_W'(1));

  // Mute rises with APPLY and is held for MUTE_CYCLES cycles after the new adder shows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mute_cnt <= '0;
      r_mute     <= 1'b0;
    end else if (w_wait_exit) begin
      r_mute <= 1'b1;
    end else if (r_state == S_APPLY) begin
      r_mute_cnt <= MUTE_W'(MUTE_CYCLES);
      r_mute     <= 1'b1;
    end else if (r_mute_cnt != '0) begin
      r_mute_cnt <= r_mute_cnt - 1'b1;
      r_mute     <= (r_mute_cnt != MUTE_W'(1));
    end
  end

  assign mute = r_mute;
`else
  assign w_mute_clear_next = 1'b1;
  assign mute              = 1'b0;
`endif

  assign cfg_ready     = r_cfg_ready;
  assign busy          = r_busy;
  assign wrap_timeout  = r_wrap_timeout;
  assign amp_req       = r_amp_req;
  assign signal_number = r_signal_number;
  assign adder         = r_adder;
  assign amp_value     = r_amp_value;

endmodule

// File: tb/tb_waveform_config_scheduler.sv
// Testbench for waveform_config_scheduler: scenario tasks driven from one
// initial block; expected commits are queued when a configuration is sent and
// popped when the commit is due.
module tb_waveform_config_scheduler;

  localparam int unsigned WRAP_TIMEOUT = 16;
  localparam int unsigned TMO_W        = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_signal_number = '0;
  logic [31:0] cfg_adder = '0;
  logic [31:0] cfg_amplitude = '0;
  logic        phase_wrap = 1'b0;
  logic [7:0]  signal_number;
  logic [31:0] adder;
  logic [31:0] amp_value;
  logic        amp_req;
  logic        amp_ack = 1'b0;
  logic        busy;
  logic        wrap_timeout;
  logic        mute;

  waveform_config_scheduler #(
    .WRAP_TIMEOUT(WRAP_TIMEOUT),
    .TMO_W(TMO_W)
`ifdef AWG_MUTE_EN
    ,
    .MUTE_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_signal_number(cfg_signal_number),
    .cfg_adder(cfg_adder),
    .cfg_amplitude(cfg_amplitude),
    .phase_wrap(phase_wrap),
    .signal_number(signal_number),
    .adder(adder),
    .amp_value(amp_value),
    .amp_req(amp_req),
    .amp_ack(amp_ack),
    .busy(busy),
    .wrap_timeout(wrap_timeout),
    .mute(mute)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  sel;
    logic [31:0] adder;
    logic [31:0] amp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Cycle counts of output activity, sampled on the falling edge.
  int mon_amp_req = 0;
  int mon_wrap_tmo = 0;
  int mon_mute = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (amp_req)      mon_amp_req++;
      if (wrap_timeout) mon_wrap_tmo++;
      if (mute)         mon_mute++;
    end
  end

  // Entered and left 1 time unit after a rising edge.
  task automatic send_cfg(input logic [7:0] sel, input logic [31:0] add, input logic [31:0] amp);
    exp_t e;
    int waited;
    waited = 0;
    while (cfg_ready !== 1'b1 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_wait: cfg_ready=%b, required 1 within 200 cycles", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_signal_number = sel;
    cfg_adder = add;
    cfg_amplitude = amp;
    e.sel = sel;
    e.adder = add;
    e.amp = amp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    $display("txn cfg sel=%0d adder=%h amp=%h accepted at %0t", sel, add, amp, $time);
  endtask

  task automatic check_commit(input string tag);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, sel=%0d adder=%h", tag, signal_number, adder);
    end else begin
      e = sb_q.pop_front();
      if (signal_number !== e.sel || adder !== e.adder) begin
        n_fail++;
        $display("FAIL %s: got sel=%0d adder=%h, required sel=%0d adder=%h",
                 tag, signal_number, adder, e.sel, e.adder);
      end else begin
        $display("txn commit %s sel=%0d adder=%h at %0t", tag, signal_number, adder, $time);
      end
    end
  endtask

  task automatic pulse_wrap();
    phase_wrap = 1'b1;
    @(posedge clk); #1;
    phase_wrap = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({signal_number, adder, amp_value, amp_req, busy, wrap_timeout, mute, cfg_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: sel=%h adder=%h amp=%h req=%b busy=%b tmo=%b mute=%b rdy=%b, required all 0",
               signal_number, adder, amp_value, amp_req, busy, wrap_timeout, mute, cfg_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_ready: cfg_ready=%b, required 0", cfg_ready);
    end
    @(negedge clk);
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_cycle: cfg_ready=%b busy=%b, required 1/0", cfg_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stopped_generator();
    int req0;
    req0 = mon_amp_req;
    send_cfg(8'd1, 32'h0000_1000, 32'h0);
    @(negedge clk);
    n_checks++;
    if (adder !== 32'h0) begin
      n_fail++;
      $display("FAIL stopped_t1: adder=%h, required 00000000", adder);
    end
    @(negedge clk);
    n_checks++;
    if (adder !== 32'h0) begin
      n_fail++;
      $display("FAIL stopped_t2: adder=%h, required 00000000", adder);
    end
    @(negedge clk);
    check_commit("stopped_t3");
    @(posedge clk); #1;
    n_checks++;
    if (mon_amp_req != req0) begin
      n_fail++;
      $display("FAIL stopped_no_amp: amp_req cycles=%0d, required 0", mon_amp_req - req0);
    end
  endtask

  task automatic test_wrap_gated();
    int req0, tmo0, early;
    send_cfg(8'd1, 32'h0100_0000, 32'h0);
    pulse_wrap();
    @(posedge clk); #1;
    check_commit("wrap_setup");
    req0 = mon_amp_req;
    tmo0 = mon_wrap_tmo;
    early = 0;
    send_cfg(8'd2, 32'h0200_0000, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) amp_ack = 1'b1;
      if (i == 5) amp_ack = 1'b0;
      @(posedge clk); #1;
      if (adder !== 32'h0100_0000 || signal_number !== 8'd1) early++;
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL wrap_hold: %0d cycles with changed outputs before wrap, required 0", early);
    end
    pulse_wrap();
    n_checks++;
    if (adder !== 32'h0100_0000) begin
      n_fail++;
      $display("FAIL wrap_plus1: adder=%h, required 01000000", adder);
    end
    @(posedge clk); #1;
    check_commit("wrap_plus2");
    @(posedge clk); #1;
    n_checks++;
    if (mon_amp_req != req0 || mon_wrap_tmo != tmo0) begin
      n_fail++;
      $display("FAIL wrap_side: amp_req cycles=%0d wrap_timeout cycles=%0d, required 0/0",
               mon_amp_req - req0, mon_wrap_tmo - tmo0);
    end
  endtask

  task automatic test_timeout();
    int tmo0, pulse_k, commit_k;
    tmo0 = mon_wrap_tmo;
    pulse_k = 0;
    commit_k = 0;
    send_cfg(8'd3, 32'h0300_0000, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (wrap_timeout === 1'b1 && pulse_k == 0) pulse_k = k;
      if (adder === 32'h0300_0000 && commit_k == 0) commit_k = k;
    end
    n_checks++;
    if (pulse_k != 16) begin
      n_fail++;
      $display("FAIL timeout_pulse_at: cycle=%0d, required 16", pulse_k);
    end
    n_checks++;
    if (commit_k != 17) begin
      n_fail++;
      $display("FAIL timeout_commit_at: cycle=%0d, required 17", commit_k);
    end
    n_checks++;
    if (mon_wrap_tmo - tmo0 != 1) begin
      n_fail++;
      $display("FAIL timeout_pulse_len: %0d cycles, required 1", mon_wrap_tmo - tmo0);
    end
    check_commit("timeout");
  endtask

  task automatic test_amp_handshake();
    exp_t e;
    int bad, rdy_bad, req0;
    bad = 0;
    rdy_bad = 0;
    send_cfg(8'd4, 32'h0400_0000, 32'h8000_0000);
    pulse_wrap();
    @(posedge clk); #1;
    check_commit("amp_commit");
    n_checks++;
    if (amp_req !== 1'b1 || amp_value !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL amp_req_start: amp_req=%b amp_value=%h, required 1/80000000", amp_req, amp_value);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        cfg_valid = 1'b1;
        cfg_signal_number = 8'd5;
        cfg_adder = 32'h0500_0000;
        cfg_amplitude = 32'h8000_0000;
      end
      if (amp_req !== 1'b1 || amp_value !== 32'h8000_0000) bad++;
      if (cfg_ready !== 1'b0) rdy_bad++;
    end
    @(posedge clk); #1;
    amp_ack = 1'b1;
    n_checks++;
    if (amp_req !== 1'b1) begin
      n_fail++;
      $display("FAIL amp_req_ack_edge: amp_req=%b, required 1", amp_req);
    end
    @(posedge clk); #1;
    n_checks++;
    if (amp_req !== 1'b0) begin
      n_fail++;
      $display("FAIL amp_req_drop: amp_req=%b, required 0", amp_req);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (amp_req !== 1'b0 || amp_value !== 32'h8000_0000) bad++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
    end
    amp_ack = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL amp_stable: %0d bad cycles of amp_req/amp_value, required 0", bad);
    end
    n_checks++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL amp_ready_low: %0d cycles with cfg_ready high or busy low, required 0", rdy_bad);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL amp_idle: cfg_ready=%b busy=%b, required 1/0", cfg_ready, busy);
    end
    // The held second configuration is taken on the next edge.
    e.sel = 8'd5;
    e.adder = 32'h0500_0000;
    e.amp = 32'h8000_0000;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    $display("txn cfg sel=5 adder=05000000 amp=80000000 accepted at %0t", $time);
    n_checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL amp_second_accept: busy=%b cfg_ready=%b, required 1/0", busy, cfg_ready);
    end
    req0 = mon_amp_req;
    pulse_wrap();
    @(posedge clk); #1;
    check_commit("amp_second");
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (mon_amp_req != req0 || amp_value !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL amp_skip_same: amp_req cycles=%0d amp_value=%h, required 0/80000000",
               mon_amp_req - req0, amp_value);
    end
  endtask

`ifdef AWG_MUTE_EN
  task automatic test_mute();
    int hi, mism;
    hi = 0;
    mism = 0;
    send_cfg(8'd7, 32'h0700_0000, 32'h8000_0000);
    pulse_wrap();
    n_checks++;
    if (mute !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_apply: mute=%b, required 1", mute);
    end
    @(posedge clk); #1;
    check_commit("mute_commit");
    for (int k = 0; k < 12; k++) begin
      if (mute === 1'b1) hi++;
      if (busy !== mute) mism++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (hi != 8) begin
      n_fail++;
      $display("FAIL mute_len: %0d cycles after adder update, required 8", hi);
    end
    n_checks++;
    if (mism != 0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_busy: %0d busy/mute mismatches cfg_ready=%b, required 0/1", mism, cfg_ready);
    end
  endtask
`else
  task automatic test_no_mute();
    n_checks++;
    if (mon_mute != 0) begin
      n_fail++;
      $display("FAIL mute_off: mute high %0d cycles, required 0", mon_mute);
    end
  endtask
`endif

  task automatic test_reset_mid_amp();
    send_cfg(8'd6, 32'h0600_0000, 32'h0000_1234);
    pulse_wrap();
    @(posedge clk); #1;
    check_commit("rst_pre_commit");
    n_checks++;
    if (amp_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_req: amp_req=%b, required 1", amp_req);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({amp_req, adder, signal_number, amp_value, busy, cfg_ready} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: req=%b adder=%h sel=%h amp=%h busy=%b rdy=%b, required all 0",
               amp_req, adder, signal_number, amp_value, busy, cfg_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: cfg_ready=%b, required 0", cfg_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cfg_ready !== 1'b1 || amp_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: cfg_ready=%b amp_req=%b, required 1/0", cfg_ready, amp_req);
    end
    send_cfg(8'd8, 32'h0800_0000, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_commit("rst_after");
  endtask

  initial begin
    test_reset();
    test_stopped_generator();
    test_wrap_gated();
    test_timeout();
    test_amp_handshake();
`ifdef AWG_MUTE_EN
    test_mute();
`else
    test_no_mute();
`endif
    test_reset_mid_amp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/waveform_config_scheduler.md
Name: waveform_config_scheduler

Overview:
- Sits in the maxClk (200 MHz) domain between the UART command decoder and the signal generator / amplitude I2C transmitter.
- Accepts a new waveform configuration (signal number, phase increment, amplitude) over a valid/ready handshake and holds it in shadow registers.
- Commits signal number and phase increment to the generator only at a phase-accumulator wrap, so waveform switches are glitch-free.
- Then sequences an amplitude update to the amplitude transmitter over a 4-phase req/ack handshake.

Parameters:
- WRAP_TIMEOUT, 1048576: cycles to wait in WAIT_WRAP for phase_wrap before forcing the commit.
- TMO_W, 21: width of the timeout counter; must satisfy 2^TMO_W > WRAP_TIMEOUT.
- MUTE_CYCLES, 64: mute hold length after commit (only with AWG_MUTE_EN).

Ports:
- clk  in  1  single clock (maxClk domain); all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  new configuration present.
- cfg_ready  out  1  block can accept a configuration.
- cfg_signal_number  in  8  requested waveform select.
- cfg_adder  in  32  requested phase increment.
- cfg_amplitude  in  32  requested amplitude code.
- phase_wrap  in  1  one-cycle pulse from the generator on accumulator wrap.
- signal_number  out  8  active waveform select to the generator.
- adder  out  32  active phase increment to the generator.
- amp_value  out  32  amplitude code to the transmitter; stable while amp_req=1.
- amp_req  out  1  amplitude update request.
- amp_ack  in  1  amplitude transmitter acknowledge.
- busy  out  1  high in any state other than IDLE, or while the mute counter is running.
- wrap_timeout  out  1  one-cycle pulse when a commit is forced by timeout.
- mute  out  1  output mute request to the generator/DAC path.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; cfg_ready=0 while reset_n=0 and 1 in the first cycle after release; shadow registers and counters cleared.
- Reset asserted mid-operation aborts immediately: amp_req drops and no partial commit remains.
- All outputs are registered.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid & cfg_ready at edge T: capture cfg_* into shadows; state=WAIT_WRAP at T+1; cfg_ready=0 from T+1.
  - cfg_valid while cfg_ready=0 is ignored; the upstream holds it.
- WAIT_WRAP:
  - Timeout counter increments from 0 each cycle.
  - Go to APPLY on any of: phase_wrap=1; current adder==0 (generator stopped, no wraps will come); counter==WRAP_TIMEOUT-1.
  - Timeout exit pulses wrap_timeout for exactly 1 cycle, coincident with the APPLY cycle.
  - phase_wrap and timeout in the same cycle count as a wrap: no wrap_timeout pulse.
- APPLY (1 cycle):
  - signal_number and adder load from shadows; new values visible the cycle after APPLY.
  - Minimum latency: accept at T, wrap at T+1, outputs change at T+3.
  - Next state: AMP_REQ if shadow amplitude != amp_value, else IDLE.
- AMP_REQ:
  - amp_value loads from shadow on entry; amp_req=1 from the same cycle, held until amp_ack=1 is sampled.
  - Next state: AMP_WAIT; amp_req deasserts on the cycle after ack is seen.
- AMP_WAIT:
  - Waits for amp_ack=0 (4-phase), then goes to IDLE.
  - An ack already low on the first AMP_WAIT cycle returns to IDLE in one cycle.
- amp_ack=1 in any state other than AMP_REQ is ignored.
- Identical back-to-back configurations still pass through WAIT_WRAP/APPLY.
- Amplitude handshake is skipped whenever the amplitude is unchanged.
- No arithmetic on data paths: pure 8/32-bit register transfers.
- Timeout counter saturates; it cannot wrap back to 0 inside WAIT_WRAP.

Optional Feature:
- Macro: AWG_MUTE_EN.
- Defined:
  - mute=1 from the APPLY cycle for MUTE_CYCLES cycles after the new adder becomes visible; a down-counter runs concurrently with the amplitude handshake.
  - busy stays 1 and cfg_ready stays 0 until both the counter is 0 and the state is IDLE.
  - Reset clears the counter and mute.
- Undefined: mute tied to 0; no counter logic; busy depends on state only.

Test Plan:
- Reset: assert reset_n=0 mid-AMP_REQ with amp_req=1 -> amp_req, adder, signal_number all 0 asynchronously; cfg_ready=1 one cycle after release.
- Wrap-gated commit: initial adder=0x0100_0000; send {sel=2, adder=0x0200_0000, amp=same}; pulse phase_wrap 10 cycles later -> adder changes exactly 2 cycles after the wrap pulse; amp_req never asserts; wrap_timeout stays 0.
- Timeout: adder nonzero, no phase_wrap, WRAP_TIMEOUT=16 -> commit after 16 WAIT_WRAP cycles; wrap_timeout high exactly 1 cycle.
- Stopped generator: adder=0, send adder=0x0000_1000 -> commit without phase_wrap; outputs change at T+3.
- Amplitude handshake: send amp=0x8000_0000 (differs); hold amp_ack low 5 cycles, then high 3, then low -> amp_req high until 1 cycle after ack rises; amp_value stable throughout; IDLE after ack falls; a second cfg_valid during this time is not accepted until cfg_ready=1.
- AWG_MUTE_EN, MUTE_CYCLES=8: any commit -> mute high for 8 cycles after the adder update; busy high until mute falls.
